// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller with a small prefetch queue.
// Generates word-aligned fetch addresses for a combinational program-memory
// read port and buffers the fetched words. Instructions go to decode over a
// valid/ready handshake. A branch redirect flushes the queue and restarts fetch.
// Optional feature macro: FETCH_DBG_PORT_EN adds a debug read port that
// time-shares the memory slot with the fetch side.
module fetch_sequencer #(
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_BYTES   = 100
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr_code,
    output logic [31:0] o_instr_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fetch_fault
`ifdef FETCH_DBG_PORT_EN
    ,
    input  logic        i_dbg_req,
    input  logic [31:0] i_dbg_addr,
    output logic        o_dbg_gnt,
    output logic        o_dbg_valid,
    output logic [31:0] o_dbg_data
`endif
);

    localparam int              PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);
    // Highest PC whose whole word still lies inside program memory.
    localparam logic [31:0]     LAST_PC  = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_nxt;

    logic [31:0]      r_q_pc   [QUEUE_DEPTH];
    logic [31:0]      r_q_code [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_flush;
    logic             w_pop;
    logic             w_push;
    logic             w_space;
    logic             w_oor;
    logic             w_fetch_want;
    logic             w_dbg_gnt;

    // A redirect is ignored only during the post-reset IDLE cycle.
    assign w_flush = i_redirect && (r_state != ST_IDLE);
    // Decode takes the head; a redirect in the same cycle cancels the pop.
    assign w_pop   = (r_count != {CNT_W{1'b0}}) && i_instr_ready && !w_flush;
    // A full queue only accepts a new word when the head leaves this cycle.
    assign w_space = (r_count != FULL_CNT) || w_pop;
    assign w_oor   = (r_fetch_pc > LAST_PC);
    // Fetch side would push this cycle if it owned the memory slot.
    assign w_fetch_want = ((r_state == ST_FETCH) || (r_state == ST_HOLD)) &&
                          !w_oor && w_space && !w_flush;

`ifdef FETCH_DBG_PORT_EN
    logic        r_last_gnt;
    logic        r_dbg_valid;
    logic [31:0] r_dbg_data;

    // Debug wins the slot unless it had the previous one and fetch needs this one.
    assign w_dbg_gnt   = i_dbg_req && (!r_last_gnt || !w_fetch_want);
    assign o_mem_addr  = w_dbg_gnt ? i_dbg_addr : r_fetch_pc;
    assign o_dbg_gnt   = w_dbg_gnt;
    assign o_dbg_valid = r_dbg_valid;
    assign o_dbg_data  = r_dbg_data;

    // Debug read capture: data registered on the grant edge, valid for one cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last_gnt  <= 1'b0;
            r_dbg_valid <= 1'b0;
            r_dbg_data  <= 32'h0000_0000;
        end else begin
            r_last_gnt  <= w_dbg_gnt;
            r_dbg_valid <= w_dbg_gnt;
            if (w_dbg_gnt) begin
                r_dbg_data <= i_mem_data;
            end
        end
    end
`else
    assign w_dbg_gnt  = 1'b0;
    assign o_mem_addr = r_fetch_pc;
`endif

    // Next-state, push decision and next fetch PC; redirect overrides everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH, ST_HOLD: begin
                if (w_dbg_gnt) begin
                    // Slot lent to debug: fetch neither pushes nor advances.
                    w_state_nxt = r_state;
                end else if (w_oor) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_space) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = ST_FETCH;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_flush) begin
            w_push         = 1'b0;
            w_state_nxt    = ST_FETCH;
            w_fetch_pc_nxt = i_redirect_pc & 32'hFFFF_FFFC;
        end else begin
            w_push = w_push;
        end
    end

    // FSM state and fetch PC registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    // Prefetch queue storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_pc[i]   <= 32'h0000_0000;
                r_q_code[i] <= 32'h0000_0000;
            end
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else if (w_flush) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_q_pc[r_tail]   <= r_fetch_pc;
                r_q_code[r_tail] <= i_mem_data;
                r_tail           <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_instr_valid = (r_count != {CNT_W{1'b0}});
    assign o_instr_code  = r_q_code[r_head];
    assign o_instr_pc    = r_q_pc[r_head];
    assign o_fetch_fault = (r_state == ST_FAULT) && (r_count == {CNT_W{1'b0}});

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed stimulus with a PC-order
// scoreboard; a monitor checks every accepted instruction against the queue.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_code;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
`ifdef FETCH_DBG_PORT_EN
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_valid;
    logic [31:0] dbg_data;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    fetch_sequencer #(
        .QUEUE_DEPTH(2),
        .RESET_PC   (32'h0000_0000),
        .MEM_BYTES  (100)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .o_mem_addr   (mem_addr),
        .i_mem_data   (mem_data),
        .o_instr_valid(instr_valid),
        .i_instr_ready(instr_ready),
        .o_instr_code (instr_code),
        .o_instr_pc   (instr_pc),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_fetch_fault(fetch_fault)
`ifdef FETCH_DBG_PORT_EN
        ,
        .i_dbg_req    (dbg_req),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_gnt    (dbg_gnt),
        .o_dbg_valid  (dbg_valid),
        .o_dbg_data   (dbg_data)
`endif
    );

    // Program memory contents: a word that is distinct from its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    assign mem_data = mem_word(mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected in-order stream from start up to the last legal PC (96).
    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (logic [31:0] p = start; p <= 32'd96; p += 32'd4) exp_q.push_back(p);
    endtask

    // Monitor: every accepted instruction must be the next expected PC.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h expected none", instr_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e);
                check("sb_code", instr_code, mem_word(e));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_code"}, instr_code, 32'd0);
        check({tag, "_pc"}, instr_pc, 32'd0);
        check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
`ifdef FETCH_DBG_PORT_EN
        check({tag, "_dbg_gnt"}, {31'd0, dbg_gnt}, 32'd0);
        check({tag, "_dbg_valid"}, {31'd0, dbg_valid}, 32'd0);
        check({tag, "_dbg_data"}, dbg_data, 32'd0);
`endif
    endtask

    // Release reset and check the IDLE cycle followed by PCs 0,4,8.
    task automatic restart_sequence(input string tag);
        step();
        rst_n = 1'b1;
        load_stream(32'd0);
        step();
        check({tag, "_idle_valid"}, {31'd0, instr_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
            check({tag, "_pc"}, instr_pc, 32'(4 * k));
            check({tag, "_code"}, instr_code, mem_word(32'(4 * k)));
        end
    endtask

    // Redirect for one cycle: one bubble cycle, then the aligned target at the head.
    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect = 1'b0;
        load_stream(target & 32'hFFFF_FFFC);
        check("redir_bubble", {31'd0, instr_valid}, 32'd0);
        check("redir_fault_clr", {31'd0, fetch_fault}, 32'd0);
        step();
        check("redir_valid", {31'd0, instr_valid}, 32'd1);
        check("redir_pc", instr_pc, target & 32'hFFFF_FFFC);
        check("redir_code", instr_code, mem_word(target & 32'hFFFF_FFFC));
    endtask

    // Wait (bounded) for Fetch_fault; everything up to PC 96 must have drained.
    task automatic wait_fault(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (!seen) begin
                if (fetch_fault) seen = 1'b1;
                else step();
            end
        end
        check({tag, "_fault"}, {31'd0, seen}, 32'd1);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
`ifdef FETCH_DBG_PORT_EN
        dbg_req  = 1'b0;
        dbg_addr = 32'd0;
`endif
        #3;
        check_reset_outputs("rst");
        step();

        // Scenario 1: reset release, streaming 0,4,8.
        restart_sequence("boot");

        // Scenario 2: decode stalls; queue fills, fetch holds at PC 8.
        instr_ready = 1'b0;
        do_redirect(32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("hold_mem_addr", mem_addr, 32'd8);
            check("hold_pc", instr_pc, 32'd0);
        end
        instr_ready = 1'b1;
        step();
        check("release_pc4", instr_pc, 32'd4);
        step();
        check("release_pc8", instr_pc, 32'd8);

        // Scenario 3: redirect to an unaligned target with a full queue.
        do_redirect(32'h0000_0013);

        // Scenario 4: stream to the end of memory and fault.
        wait_fault("end_stream");

        // Scenario 4b: entries present at fault entry still drain first.
        instr_ready = 1'b0;
        do_redirect(32'd88);
        for (int k = 0; k < 3; k++) begin
            step();
            check("drain_fault_low", {31'd0, fetch_fault}, 32'd0);
            check("drain_mem_addr", mem_addr, 32'd96);
        end
        instr_ready = 1'b1;
        wait_fault("drain");

        // Redirect clears the fault and restarts at 0.
        do_redirect(32'd0);

`ifdef FETCH_DBG_PORT_EN
        // Scenario 5: debug requests alternate with the fetch stream.
        begin
            logic        prev_gnt;
            logic [31:0] prev_addr;
            prev_gnt  = 1'b0;
            prev_addr = 32'd0;
            for (int k = 0; k < 8; k++) begin
                dbg_req  = 1'b1;
                dbg_addr = 32'h40 + 32'(4 * k);
                #1;
                check("dbg_gnt", {31'd0, dbg_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
                if (k % 2 == 0) check("dbg_mem_addr", mem_addr, dbg_addr);
                check("dbg_valid", {31'd0, dbg_valid}, {31'd0, prev_gnt});
                if (prev_gnt) check("dbg_data", dbg_data, mem_word(prev_addr));
                prev_gnt  = dbg_gnt;
                prev_addr = dbg_addr;
                step();
            end
            dbg_req = 1'b0;
            check("dbg_valid_last", {31'd0, dbg_valid}, {31'd0, prev_gnt});
            step();
        end
`endif

        // Scenario 6: asynchronous reset mid-stream, then restart.
        step();
        step();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_rst");
        step();
        restart_sequence("restart");

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound in case the run stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
